// File: rtl/obi_avalon_arbiter_pkg.sv
// Shared types and byte-lane helpers for the OBI-to-Avalon arbiter.
// Byte-lane reordering is sized for the widest supported word.
package obi_avalon_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CMD   = 2'd1,
      RDATA = 2'd2
   } arb_state_e;

   localparam int unsigned ByteWidth       = 8;
   localparam int unsigned MaxBytesPerWord = 32;
   localparam int unsigned MaxDataWidth    = MaxBytesPerWord * ByteWidth;

   // Byte i of the low nbytes lanes moves to lane nbytes-1-i; upper lanes read as zero.
   function automatic logic [MaxDataWidth-1:0] byte_swap(input logic [MaxDataWidth-1:0] d,
                                                         input int unsigned nbytes);
      logic [MaxDataWidth-1:0] r;
      r = '0;
      for (int unsigned i = 0; i < MaxBytesPerWord; i++) begin
         if (i < nbytes) begin
            r[i*ByteWidth +: ByteWidth] = d[(nbytes-1-i)*ByteWidth +: ByteWidth];
         end
      end
      return r;
   endfunction

   function automatic logic [MaxBytesPerWord-1:0] be_reverse(input logic [MaxBytesPerWord-1:0] be,
                                                             input int unsigned nbytes);
      logic [MaxBytesPerWord-1:0] r;
      r = '0;
      for (int unsigned i = 0; i < MaxBytesPerWord; i++) begin
         if (i < nbytes) begin
            r[i] = be[nbytes-1-i];
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/obi_avalon_arbiter_picker.sv
// Request picker: fixed lowest-index priority, or round-robin search
// starting one past the last winner.
module rr_priority_picker #(
   parameter int unsigned NumPorts   = 2,
   parameter bit          RoundRobin = 1'b1,
   localparam int unsigned PtrW      = (NumPorts > 1) ? $clog2(NumPorts) : 1
) (
   input  logic [NumPorts-1:0] req_i,
   input  logic [PtrW-1:0]     ptr_i,
   output logic [NumPorts-1:0] winner_o,
   output logic [PtrW-1:0]     idx_o
);

   int unsigned     cand;
   logic [PtrW-1:0] cand_idx;
   logic            found;

   always_comb begin
      winner_o = '0;
      idx_o    = '0;
      found    = 1'b0;
      cand     = 0;
      cand_idx = '0;
      for (int unsigned k = 0; k < NumPorts; k++) begin
         cand     = RoundRobin ? (32'(ptr_i) + 1 + k) % NumPorts : k;
         cand_idx = PtrW'(cand);
         if (!found && req_i[cand_idx]) begin
            found              = 1'b1;
            idx_o              = cand_idx;
            winner_o[cand_idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/obi_avalon_arbiter.sv
// N-port req/gnt/rvalid arbiter onto a single Avalon-MM host, one
// transaction outstanding, optional per-port byte-lane swap.
module obi_avalon_arbiter
   import obi_avalon_arbiter_pkg::*;
#(
   parameter int unsigned         NumPorts   = 2,
   parameter int unsigned         AddrWidth  = 32,
   parameter int unsigned         DataWidth  = 32,
   parameter int unsigned         AddrShift  = 2,
   parameter bit                  RoundRobin = 1'b1,
   parameter logic [NumPorts-1:0] SwapMask   = '0
) (
   input  logic                              clk_i,
   input  logic                              rst_ni,
   input  logic [NumPorts-1:0]               req_i,
   input  logic [NumPorts-1:0]               we_i,
   input  logic [NumPorts*DataWidth/8-1:0]   be_i,
   input  logic [NumPorts*AddrWidth-1:0]     addr_i,
   input  logic [NumPorts*DataWidth-1:0]     wdata_i,
   output logic [NumPorts-1:0]               gnt_o,
   output logic [NumPorts-1:0]               rvalid_o,
   output logic [DataWidth-1:0]              rdata_o,
   output logic [AddrWidth-1:0]              avm_address_o,
   output logic                              avm_read_o,
   output logic                              avm_write_o,
   output logic [DataWidth/8-1:0]            avm_byteenable_o,
   output logic [DataWidth-1:0]              avm_writedata_o,
   input  logic                              avm_waitrequest_i,
   input  logic [DataWidth-1:0]              avm_readdata_i,
   input  logic                              avm_readdatavalid_i,
   output logic                              busy_o,
   output logic                              err_o
);

   localparam int unsigned BytesPerWord = DataWidth / ByteWidth;
   localparam int unsigned PtrW         = (NumPorts > 1) ? $clog2(NumPorts) : 1;

   arb_state_e             state_q, state_d;
   logic [PtrW-1:0]        ptr_q, owner_q, win_idx;
   logic [NumPorts-1:0]    win_oh, rvalid_q, rvalid_d;
   logic                   grant, we_q, err_q, sel_swap;
   logic [BytesPerWord-1:0] be_q, sel_be, be_cap;
   logic [DataWidth-1:0]   wdata_q, sel_wdata, wdata_cap, rdata_q, rdata_cap;
   logic [AddrWidth-1:0]   addr_q, sel_addr;
   logic [MaxBytesPerWord-1:0] be_sw;
   logic [MaxDataWidth-1:0]    wdata_sw, rdata_sw;

   rr_priority_picker #(
      .NumPorts   (NumPorts),
      .RoundRobin (RoundRobin)
   ) u_picker (
      .req_i    (req_i),
      .ptr_i    (ptr_q),
      .winner_o (win_oh),
      .idx_o    (win_idx)
   );

   // Winner's request fields, byte-swapped before capture when its SwapMask bit is set.
   always_comb begin
      sel_be    = be_i[32'(win_idx)*BytesPerWord +: BytesPerWord];
      sel_wdata = wdata_i[32'(win_idx)*DataWidth +: DataWidth];
      sel_addr  = addr_i[32'(win_idx)*AddrWidth +: AddrWidth];
      sel_swap  = SwapMask[win_idx];
      be_sw     = be_reverse(MaxBytesPerWord'(sel_be), BytesPerWord);
      wdata_sw  = byte_swap(MaxDataWidth'(sel_wdata), BytesPerWord);
      be_cap    = sel_swap ? be_sw[BytesPerWord-1:0] : sel_be;
      wdata_cap = sel_swap ? wdata_sw[DataWidth-1:0] : sel_wdata;
      rdata_sw  = byte_swap(MaxDataWidth'(avm_readdata_i), BytesPerWord);
      rdata_cap = SwapMask[owner_q] ? rdata_sw[DataWidth-1:0] : avm_readdata_i;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (|req_i) state_d = CMD;
         CMD:     if (!avm_waitrequest_i) state_d = we_q ? IDLE : RDATA;
         RDATA:   if (avm_readdatavalid_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      grant       = (state_q == IDLE) && (|req_i);
      gnt_o       = (grant && rst_ni) ? win_oh : '0;
      avm_read_o  = (state_q == CMD) && !we_q;
      avm_write_o = (state_q == CMD) && we_q;
      busy_o      = (state_q != IDLE);
      rvalid_d    = '0;
      if ((state_q == CMD) && !avm_waitrequest_i && we_q) rvalid_d[owner_q] = 1'b1;
      if ((state_q == RDATA) && avm_readdatavalid_i)      rvalid_d[owner_q] = 1'b1;
   end

   // Command capture, response pulse and sticky error; everything clears on reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ptr_q    <= PtrW'(NumPorts - 1);
         owner_q  <= '0;
         we_q     <= 1'b0;
         be_q     <= '0;
         wdata_q  <= '0;
         addr_q   <= '0;
         rvalid_q <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         if (grant) begin
            owner_q <= win_idx;
            we_q    <= we_i[win_idx];
            be_q    <= be_cap;
            wdata_q <= wdata_cap;
            addr_q  <= sel_addr >> AddrShift;
            if (RoundRobin) ptr_q <= win_idx;
         end
         rvalid_q <= rvalid_d;
         if ((state_q == RDATA) && avm_readdatavalid_i) rdata_q <= rdata_cap;
         if ((state_q != RDATA) && avm_readdatavalid_i) err_q <= 1'b1;
      end
   end

   assign rvalid_o         = rvalid_q;
   assign rdata_o          = rdata_q;
   assign avm_address_o    = addr_q;
   assign avm_byteenable_o = be_q;
   assign avm_writedata_o  = wdata_q;
   assign err_o            = err_q;

endmodule

// File: tb/tb_obi_avalon_arbiter.sv
// Directed bench: 2-port round-robin with port-1 swap, 4-port round-robin,
// and 2-port fixed priority instances sharing one clock and reset.
module tb_obi_avalon_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   int n_chk  = 0;
   int n_pass = 0;

   // Instance A: 2 ports, round-robin, SwapMask = 2'b10
   logic [1:0]  a_req, a_we, a_gnt, a_rvalid;
   logic [7:0]  a_be;
   logic [63:0] a_addr, a_wdata;
   logic [31:0] a_rdata, a_adr, a_wd, a_rdin;
   logic        a_rd, a_wr, a_wait, a_rdv, a_busy, a_err;
   logic [3:0]  a_bey;

   // Instance B: 4 ports, round-robin
   logic [3:0]   b_req, b_we, b_gnt, b_rvalid, b_bey;
   logic [15:0]  b_be;
   logic [127:0] b_addr, b_wdata;
   logic [31:0]  b_rdata, b_adr, b_wd;
   logic         b_rd, b_wr, b_busy, b_err;

   // Instance C: 2 ports, fixed priority
   logic [1:0]  c_req, c_we, c_gnt, c_rvalid;
   logic [7:0]  c_be;
   logic [63:0] c_addr, c_wdata;
   logic [31:0] c_rdata, c_adr, c_wd;
   logic [3:0]  c_bey;
   logic        c_rd, c_wr, c_busy, c_err;

   obi_avalon_arbiter #(.NumPorts(2), .RoundRobin(1'b1), .SwapMask(2'b10)) u_a (
      .clk_i(clk), .rst_ni(rst_n), .req_i(a_req), .we_i(a_we), .be_i(a_be),
      .addr_i(a_addr), .wdata_i(a_wdata), .gnt_o(a_gnt), .rvalid_o(a_rvalid),
      .rdata_o(a_rdata), .avm_address_o(a_adr), .avm_read_o(a_rd), .avm_write_o(a_wr),
      .avm_byteenable_o(a_bey), .avm_writedata_o(a_wd), .avm_waitrequest_i(a_wait),
      .avm_readdata_i(a_rdin), .avm_readdatavalid_i(a_rdv), .busy_o(a_busy), .err_o(a_err));

   obi_avalon_arbiter #(.NumPorts(4), .RoundRobin(1'b1), .SwapMask(4'b0000)) u_b (
      .clk_i(clk), .rst_ni(rst_n), .req_i(b_req), .we_i(b_we), .be_i(b_be),
      .addr_i(b_addr), .wdata_i(b_wdata), .gnt_o(b_gnt), .rvalid_o(b_rvalid),
      .rdata_o(b_rdata), .avm_address_o(b_adr), .avm_read_o(b_rd), .avm_write_o(b_wr),
      .avm_byteenable_o(b_bey), .avm_writedata_o(b_wd), .avm_waitrequest_i(1'b0),
      .avm_readdata_i(32'h0), .avm_readdatavalid_i(1'b0), .busy_o(b_busy), .err_o(b_err));

   obi_avalon_arbiter #(.NumPorts(2), .RoundRobin(1'b0), .SwapMask(2'b00)) u_c (
      .clk_i(clk), .rst_ni(rst_n), .req_i(c_req), .we_i(c_we), .be_i(c_be),
      .addr_i(c_addr), .wdata_i(c_wdata), .gnt_o(c_gnt), .rvalid_o(c_rvalid),
      .rdata_o(c_rdata), .avm_address_o(c_adr), .avm_read_o(c_rd), .avm_write_o(c_wr),
      .avm_byteenable_o(c_bey), .avm_writedata_o(c_wd), .avm_waitrequest_i(1'b0),
      .avm_readdata_i(32'h0), .avm_readdatavalid_i(1'b0), .busy_o(c_busy), .err_o(c_err));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   initial begin
      rst_n  = 1'b0;
      a_req = 2'b11; a_we = '0; a_be = '0; a_addr = '0; a_wdata = '0;
      a_wait = 1'b0; a_rdv = 1'b0; a_rdin = '0;
      b_req = '1; b_we = '0; b_be = '0; b_addr = '0; b_wdata = '0;
      c_req = '0; c_we = '0; c_be = '0; c_addr = '0; c_wdata = '0;
      repeat (2) tick();

      chk("rst_gnt_a", 64'(a_gnt), 64'h0);
      chk("rst_gnt_b", 64'(b_gnt), 64'h0);
      chk("rst_read", 64'(a_rd), 64'h0);
      chk("rst_write", 64'(a_wr), 64'h0);
      chk("rst_rvalid", 64'(a_rvalid), 64'h0);
      chk("rst_rdata", 64'(a_rdata), 64'h0);
      chk("rst_err", 64'(a_err), 64'h0);
      chk("rst_busy", 64'(a_busy), 64'h0);
      chk("rst_addr", 64'(a_adr), 64'h0);
      a_req = '0; b_req = '0; rst_n = 1'b1;
      tick();

      // 4-port round-robin and 2-port fixed priority, all ports requesting writes
      b_req = '1; b_we = '1; c_req = 2'b11; c_we = 2'b11;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("rr4_gnt", 64'(b_gnt), 64'(1 << (i % 4)));
         chk("fixed_gnt", 64'(c_gnt), 64'h1);
         if (i > 0) chk("rr4_rvalid", 64'(b_rvalid), 64'(1 << ((i - 1) % 4)));
         tick();
         tick();
      end
      b_req = '0; c_req = '0;
      tick();
      chk("b_idle", 64'(b_busy), 64'h0);
      chk("c_rvalid", 64'(c_rvalid), 64'h0);

      // Port 1 read of 0x40, zero wait states, readdata latency 1, swapped port
      a_req = 2'b10; a_we = 2'b00; a_addr = {32'h40, 32'h0};
      #1 chk("rd_gnt", 64'(a_gnt), 64'h2);
      tick();
      a_req = '0;
      chk("rd_cmd_read", 64'(a_rd), 64'h1);
      chk("rd_cmd_write", 64'(a_wr), 64'h0);
      chk("rd_cmd_addr", 64'(a_adr), 64'h10);
      chk("rd_cmd_gnt", 64'(a_gnt), 64'h0);
      tick();
      a_rdv = 1'b1; a_rdin = 32'h11223344;
      chk("rd_rdata_read", 64'(a_rd), 64'h0);
      chk("rd_rdata_busy", 64'(a_busy), 64'h1);
      tick();
      a_rdv = 1'b0;
      chk("rd_rvalid", 64'(a_rvalid), 64'h2);
      chk("rd_rdata", 64'(a_rdata), 64'h44332211);
      tick();
      chk("rd_rvalid_pulse", 64'(a_rvalid), 64'h0);

      // Port 0 write with three wait-state cycles
      a_req = 2'b01; a_we = 2'b01; a_be = 8'h03; a_addr = {32'h0, 32'h100};
      a_wdata = {32'h0, 32'hAABBCCDD}; a_wait = 1'b1;
      #1 chk("wr_gnt", 64'(a_gnt), 64'h1);
      tick();
      a_req = '0;
      for (int k = 0; k < 3; k++) begin
         chk("wr_hold_write", 64'(a_wr), 64'h1);
         chk("wr_hold_be", 64'(a_bey), 64'h3);
         chk("wr_hold_data", 64'(a_wd), 64'hAABBCCDD);
         chk("wr_hold_addr", 64'(a_adr), 64'h40);
         chk("wr_hold_rvalid", 64'(a_rvalid), 64'h0);
         tick();
      end
      a_wait = 1'b0;
      chk("wr_accept_write", 64'(a_wr), 64'h1);
      tick();
      chk("wr_rvalid", 64'(a_rvalid), 64'h1);
      chk("wr_done_write", 64'(a_wr), 64'h0);
      chk("wr_done_busy", 64'(a_busy), 64'h0);

      // Port 1 write through the byte-swap path
      a_req = 2'b10; a_we = 2'b10; a_be = 8'h10; a_addr = {32'h8, 32'h0};
      a_wdata = {32'h01020304, 32'h0};
      #1 chk("swwr_gnt", 64'(a_gnt), 64'h2);
      tick();
      a_req = '0;
      chk("swwr_be", 64'(a_bey), 64'h8);
      chk("swwr_data", 64'(a_wd), 64'h04030201);
      chk("swwr_addr", 64'(a_adr), 64'h2);
      tick();
      chk("swwr_rvalid", 64'(a_rvalid), 64'h2);

      // Both ports requesting: last winner was port 1, so 0,1,0,1
      a_req = 2'b11; a_we = 2'b11;
      for (int i = 0; i < 4; i++) begin
         #1 chk("rr2_gnt", 64'(a_gnt), (i % 2 == 0) ? 64'h1 : 64'h2);
         tick();
         chk("rr2_cmd_gnt", 64'(a_gnt), 64'h0);
         if (i == 3) a_req = '0;
         tick();
      end

      // Stray readdatavalid while idle
      a_rdv = 1'b1; a_rdin = 32'hDEADBEEF;
      tick();
      a_rdv = 1'b0;
      chk("stray_err", 64'(a_err), 64'h1);
      chk("stray_rvalid", 64'(a_rvalid), 64'h0);
      chk("stray_busy", 64'(a_busy), 64'h0);
      repeat (2) tick();
      chk("stray_err_sticky", 64'(a_err), 64'h1);

      // Reset while a read command is stalled
      a_req = 2'b01; a_we = 2'b00; a_wait = 1'b1;
      tick();
      a_req = '0;
      chk("rstmid_read", 64'(a_rd), 64'h1);
      rst_n = 1'b0;
      #1;
      chk("rstmid_read_drop", 64'(a_rd), 64'h0);
      chk("rstmid_write_drop", 64'(a_wr), 64'h0);
      chk("rstmid_err_clr", 64'(a_err), 64'h0);
      chk("rstmid_busy", 64'(a_busy), 64'h0);
      tick();
      rst_n = 1'b1; a_wait = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk("rstmid_no_rvalid", 64'(a_rvalid), 64'h0);
         chk("rstmid_idle", 64'(a_busy), 64'h0);
         chk("rstmid_no_read", 64'(a_rd), 64'h0);
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/obi_avalon_arbiter.md
Name: obi_avalon_arbiter

Overview:
- N-port arbiter mapping ibex-style req/gnt/rvalid data ports onto a single Avalon-MM host interface (EPCQ/flash controller, on-chip memories).
- Successor to the fixed two-way instr/data flash state machine; generalises port count, widths and priority mode.
- Adds per-port byte-swap, configurable word-address shift and a sticky protocol-error flag.
- One transaction outstanding at a time.

Parameters:
- NumPorts, 2, number of host ports; index 0 is highest fixed priority.
- AddrWidth, 32, byte-address width on the host side and Avalon side.
- DataWidth, 32, data width; must be a multiple of 8.
- AddrShift, 2, right shift converting a byte address to an Avalon word address.
- RoundRobin, 1'b1, 1 = round-robin arbitration, 0 = fixed priority (lowest index wins).
- SwapMask, '0, NumPorts bits; bit p set = byte-reverse wdata, rdata and be for port p.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- req_i  in  NumPorts  per-port request; held until granted.
- we_i  in  NumPorts  per-port write enable.
- be_i  in  NumPorts*DataWidth/8  per-port byte enables, port p at slice p.
- addr_i  in  NumPorts*AddrWidth  per-port byte addresses.
- wdata_i  in  NumPorts*DataWidth  per-port write data.
- gnt_o  out  NumPorts  one-hot grant.
- rvalid_o  out  NumPorts  one-hot response valid: read data or write completion.
- rdata_o  out  DataWidth  shared read data, qualified by rvalid_o.
- avm_address_o  out  AddrWidth  word address.
- avm_read_o  out  1  Avalon read.
- avm_write_o  out  1  Avalon write.
- avm_byteenable_o  out  DataWidth/8  Avalon byte enables.
- avm_writedata_o  out  DataWidth  Avalon write data.
- avm_waitrequest_i  in  1  Avalon stall.
- avm_readdata_i  in  DataWidth  Avalon read data.
- avm_readdatavalid_i  in  1  Avalon read data valid.
- busy_o  out  1  high when state != IDLE.
- err_o  out  1  sticky protocol error.

Behaviour:
- Reset values:
  - state = IDLE.
  - All avm_* outputs 0; rvalid_o, rdata_o and err_o 0.
  - Round-robin pointer = NumPorts-1, so port 0 wins first.
  - gnt_o is combinational and is 0 during reset.
- Reset mid-transaction: the Avalon command is dropped, no rvalid is issued, and all state is cleared.
- States: IDLE, CMD, RDATA.
- IDLE:
  - If any req_i is high, the winner w gets gnt_o[w]=1 in the same cycle (combinational).
  - Capture into registers: owner=w, we, the (optionally swapped) be and wdata, and address = addr_i[w] >> AddrShift.
  - Next state is CMD. gnt_o is 0 in all other states.
- Arbitration:
  - Fixed mode: lowest set index wins.
  - Round-robin mode: search starts at pointer+1, modulo NumPorts; pointer <= w on grant.
- CMD:
  - Drive avm_read_o = ~we or avm_write_o = we, with address, byteenable and writedata held stable.
  - If avm_waitrequest_i=0 (command accepted): a write goes to IDLE with rvalid_o[owner]=1 next cycle; a read goes to RDATA.
  - If avm_waitrequest_i=1, stay in CMD with all outputs held.
- RDATA:
  - avm_read_o=0.
  - On avm_readdatavalid_i, register rdata_o (swapped if SwapMask[owner]) and pulse rvalid_o[owner] for one cycle; next state IDLE.
- rvalid_o is a registered single-cycle pulse.
- A new grant may occur in the same cycle rvalid_o is high, because state is already IDLE.
- Minimum read latency (no wait, Avalon latency 1): gnt at cycle 0, avm_read at 1, readdatavalid at 2, rvalid_o at 3.
- Minimum write latency: gnt at 0, avm_write at 1, rvalid_o at 2.
- Byte swap: byte i maps to byte DataWidth/8-1-i; the same bit reversal applies to be.
- Error: avm_readdatavalid_i seen outside RDATA sets err_o, which stays set until reset; the data is ignored and there is no rvalid.
- Simultaneous requests: exactly one grant per IDLE cycle; losers keep req_i high and are served later.

Decomposition:
- Package obi_avalon_arbiter_pkg holds:
  - the arb_state_e enum {IDLE, CMD, RDATA};
  - a byte-swap function;
  - a localparam for bytes-per-word.
- Sub-module rr_priority_picker, parameterised by NumPorts and RoundRobin: takes req and pointer, outputs a one-hot winner and its index.

Test Plan:
- Port 1 read of addr 0x40, no wait states, readdata 0x11223344 at latency 1 -> avm_address 0x10; rvalid_o=2'b10 at cycle 3 with rdata 0x11223344 (0x44332211 if SwapMask=2'b10).
- Port 0 write, be=4'b0011, wdata 0xAABBCCDD, waitrequest high for 3 cycles -> avm_write held 4 cycles with signals stable; rvalid_o[0] on the cycle after accept.
- Both ports requesting continuously with RoundRobin=1 -> grants alternate 0,1,0,1; with RoundRobin=0, port 0 always wins.
- NumPorts=4, all requesting, RoundRobin=1 -> grant order 0,1,2,3,0, each exactly once per 4 transactions.
- Stray avm_readdatavalid_i while in IDLE -> err_o=1 and stays 1, no rvalid_o; cleared only by rst_ni.
- rst_ni asserted while in CMD -> avm_read_o and avm_write_o go to 0 immediately; after release, state is IDLE and no rvalid_o is issued for the dropped transaction.
